hex_display_scroller: RTL and testbench



---
 rtl/hex_display_scroller.sv | 130 +++++++++++++
 tb/tb_hex_display_scroller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scroller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_display_scroller : six-digit HEX front-end, static / scroll / blank     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hex_display_scroller #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [1:0]  mode,
    input  logic        lz_en,
    output logic [23:0] digit_nibbles,
    output logic [5:0]  digit_blank,
    output logic [3:0]  window_pos,
    output logic        scroll_tick
);

    localparam int                 CNT_W       = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0]         MODE_LOW    = 2'b00;
    localparam logic [1:0]         MODE_HIGH   = 2'b01;
    localparam logic [1:0]         MODE_SCROLL = 2'b10;
    localparam logic [3:0]         W_LAST      = 4'd9;

    logic [31:0]      data_q, data_d;
    logic [3:0]       w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic [23:0]      nib_q, nib_d;
    logic [5:0]       blank_q, blank_d;
    logic [3:0]       wpos_q;
    logic             tick_q;

    logic [4:0]       pos_sum;
    logic [3:0]       pos;
    logic             lz_run;

    // Prescaler and window position; anything other than scrolling parks them at 0.
    always_comb begin
        data_d = data_q;
        w_d    = 4'd0;
        cnt_d  = '0;
        step_d = 1'b0;
        if (load) begin
            data_d = data_in;
        end else if (mode == MODE_SCROLL) begin
            if (cnt_q == CNT_LAST) begin
                step_d = 1'b1;
                w_d    = (w_q == W_LAST) ? 4'd0 : w_q + 4'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                w_d   = w_q;
            end
        end
    end

    always_comb begin
        nib_d   = '0;
        blank_d = '0;
        pos_sum = '0;
        pos     = '0;
        lz_run  = 1'b1;
        case (mode)
            MODE_LOW: begin
                for (int i = 0; i < 6; i++)
                    nib_d[4*i +: 4] = data_q[4*i +: 4];
            end
            MODE_HIGH: begin
                for (int i = 0; i < 6; i++)
                    nib_d[4*i +: 4] = data_q[4*i + 8 +: 4];
            end
            MODE_SCROLL: begin
                // Ring of 10: positions 8 and 9 are the dark gap between repeats.
                for (int i = 0; i < 6; i++) begin
                    pos_sum = {1'b0, w_q} + 5'(i);
                    pos     = (pos_sum >= 5'd10) ? 4'(pos_sum - 5'd10) : 4'(pos_sum);
                    if (pos[3])
                        blank_d[i] = 1'b1;
                    else
                        nib_d[4*i +: 4] = data_q[{pos[2:0], 2'b00} +: 4];
                end
            end
            default: begin
                blank_d = 6'h3F;
            end
        endcase

        if (lz_en && !mode[1]) begin
            for (int i = 5; i >= 1; i--) begin
                if (lz_run && (nib_d[4*i +: 4] == 4'd0))
                    blank_d[i] = 1'b1;
                else
                    lz_run = 1'b0;
            end
        end
    end

    // The tick is delayed one edge so it lines up with window_pos showing the new w.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            nib_q   <= '0;
            blank_q <= 6'h3F;
            wpos_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            nib_q   <= nib_d;
            blank_q <= blank_d;
            wpos_q  <= w_q;
            tick_q  <= step_q;
        end
    end

    assign digit_nibbles = nib_q;
    assign digit_blank   = blank_q;
    assign window_pos    = wpos_q;
    assign scroll_tick   = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scroller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hex_display_scroller : bench for hex_display_scroller (TICK_DIV = 4)     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_hex_display_scroller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [1:0]  mode = 2'b00;
    logic        lz_en = 1'b0;
    logic [23:0] digit_nibbles;
    logic [5:0]  digit_blank;
    logic [3:0]  window_pos;
    logic        scroll_tick;

    hex_display_scroller #(.TICK_DIV(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .data_in       (data_in),
        .mode          (mode),
        .lz_en         (lz_en),
        .digit_nibbles (digit_nibbles),
        .digit_blank   (digit_blank),
        .window_pos    (window_pos),
        .scroll_tick   (scroll_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [23:0] nib;
        logic [5:0]  bl;
        logic [3:0]  wp;
        logic        tk;
        string       name;
    } exp_t;

    typedef struct {
        logic        ld;
        logic [31:0] d;
        logic [1:0]  m;
        logic        lz;
        logic [23:0] nib;
        logic [5:0]  bl;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            checks++;
            if (digit_nibbles !== cur.nib || digit_blank !== cur.bl ||
                window_pos !== cur.wp || scroll_tick !== cur.tk) begin
                errors++;
                $display("FAIL %s @cyc %0d: got nib=%h blank=%b wpos=%0d tick=%b, want nib=%h blank=%b wpos=%0d tick=%b",
                         cur.name, cyc, digit_nibbles, digit_blank, window_pos, scroll_tick,
                         cur.nib, cur.bl, cur.wp, cur.tk);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic push(input int due, input logic [23:0] nib, input logic [5:0] bl,
                        input logic [3:0] wp, input logic tk, input string nm);
        exp_t e;
        int   idx;
        e.due = due; e.nib = nib; e.bl = bl; e.wp = wp; e.tk = tk; e.name = nm;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].due > due) idx--;
        sb.insert(idx, e);
    endtask

    // Ring model: positions 0..7 are nibbles, 8..9 are dark gap digits.
    task automatic push_sc(input int due, input logic [31:0] word, input int w,
                           input logic tk, input string nm);
        logic [23:0] nib;
        logic [5:0]  bl;
        int          p;
        nib = '0;
        bl  = '0;
        for (int i = 0; i < 6; i++) begin
            p = (w + i) % 10;
            if (p < 8) nib[4*i +: 4] = word[4*p +: 4];
            else       bl[i] = 1'b1;
        end
        push(due, nib, bl, 4'(w), tk, nm);
    endtask

    vec_t vecs[11];

    initial begin
        int l1, l2, d0, e0, guard;

        vecs[0]  = '{1'b1, 32'h12345678, 2'b00, 1'b0, 24'h345678, 6'b000000};
        vecs[1]  = '{1'b0, 32'h0,        2'b01, 1'b0, 24'h123456, 6'b000000};
        vecs[2]  = '{1'b0, 32'h0,        2'b11, 1'b0, 24'h000000, 6'b111111};
        vecs[3]  = '{1'b0, 32'h0,        2'b01, 1'b1, 24'h123456, 6'b000000};
        vecs[4]  = '{1'b1, 32'h00000A05, 2'b00, 1'b1, 24'h000A05, 6'b111000};
        vecs[5]  = '{1'b1, 32'h00000000, 2'b00, 1'b1, 24'h000000, 6'b111110};
        vecs[6]  = '{1'b0, 32'h0,        2'b01, 1'b1, 24'h000000, 6'b111110};
        vecs[7]  = '{1'b1, 32'h00A00000, 2'b01, 1'b1, 24'h00A000, 6'b110000};
        vecs[8]  = '{1'b0, 32'h0,        2'b01, 1'b0, 24'h00A000, 6'b000000};
        vecs[9]  = '{1'b1, 32'h0000F000, 2'b11, 1'b1, 24'h000000, 6'b111111};
        vecs[10] = '{1'b1, 32'h80000001, 2'b00, 1'b1, 24'h000001, 6'b111110};

        // Reset held for two edges, then release in static-low mode.
        step();
        step();
        push(cyc, 24'h0, 6'h3F, 4'd0, 1'b0, "reset");
        rst_n = 1'b1;
        push(cyc + 1, 24'h0, 6'h00, 4'd0, 1'b0, "post_reset");
        step();

        for (int k = 0; k < 11; k++) begin
            load    = vecs[k].ld;
            if (vecs[k].ld) data_in = vecs[k].d;
            mode    = vecs[k].m;
            lz_en   = vecs[k].lz;
            push(cyc + (vecs[k].ld ? 2 : 1), vecs[k].nib, vecs[k].bl, 4'd0, 1'b0,
                 $sformatf("vec%0d", k));
            step();
            load = 1'b0;
            if (vecs[k].ld) step();
        end

        // Scroll walk: load in scroll mode, w=k visible from edge l1+1+4k.
        load = 1'b1; data_in = 32'h12345678; mode = 2'b10; lz_en = 1'b1;
        l1 = cyc + 1;
        for (int j = 0; j < 45; j++)
            push_sc(l1 + 1 + j, 32'h12345678, (j / 4) % 10, (j > 0) && (j % 4 == 0),
                    $sformatf("walk_j%0d", j));
        push(l1 + 1,  24'h345678, 6'b000000, 4'd0, 1'b0, "walk_w0");
        push(l1 + 5,  24'h234567, 6'b000000, 4'd1, 1'b1, "walk_w1");
        push(l1 + 13, 24'h012345, 6'b100000, 4'd3, 1'b1, "walk_w3");
        push(l1 + 37, 24'h456780, 6'b000001, 4'd9, 1'b1, "walk_w9");
        push(l1 + 41, 24'h345678, 6'b000000, 4'd0, 1'b1, "walk_wrap");
        step();
        load = 1'b0;
        wait_until(l1 + 46);

        // Load collides with the terminal count that would step w from 5 to 6.
        load = 1'b1; data_in = 32'h12345678;
        l2 = cyc + 1;
        push_sc(l2 + 21, 32'h12345678, 5, 1'b1, "coll_w5");
        for (int j = 22; j <= 24; j++)
            push_sc(l2 + j, 32'h12345678, 5, 1'b0, "coll_hold");
        for (int j = 25; j <= 28; j++)
            push_sc(l2 + j, 32'h9ABCDEF0, 0, 1'b0, "coll_restart");
        push_sc(l2 + 29, 32'h9ABCDEF0, 1, 1'b1, "coll_next_tick");
        step();
        load = 1'b0;
        wait_until(l2 + 23);
        load = 1'b1; data_in = 32'h9ABCDEF0;
        step();
        load = 1'b0;

        // Leave scroll mid-count, then come back: restarts at w=0.
        wait_until(l2 + 30);
        d0 = cyc;
        mode = 2'b00;
        push(d0 + 2, 24'hBCDEF0, 6'b000000, 4'd0, 1'b0, "mode_leave");
        wait_until(d0 + 2);
        mode = 2'b10;
        e0 = d0 + 3;
        for (int j = 0; j < 4; j++)
            push_sc(e0 + j, 32'h9ABCDEF0, 0, 1'b0, "reenter_w0");
        push_sc(e0 + 4, 32'h9ABCDEF0, 1, 1'b1, "reenter_w1");
        push_sc(e0 + 28, 32'h9ABCDEF0, 7, 1'b1, "pre_reset_w7");
        push(e0 + 29, 24'h0, 6'h3F, 4'd0, 1'b0, "mid_reset");
        push(e0 + 30, 24'h0, 6'h3F, 4'd0, 1'b0, "mid_reset_hold");
        for (int j = 31; j <= 34; j++)
            push_sc(e0 + j, 32'h0, 0, 1'b0, "post_reset_w0");
        push_sc(e0 + 35, 32'h0, 1, 1'b1, "post_reset_w1");

        // Reset during scroll while w=7 is on the outputs.
        wait_until(e0 + 28);
        rst_n = 1'b0;
        wait_until(e0 + 30);
        rst_n = 1'b1;
        wait_until(e0 + 36);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            step();
            guard++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
            errors += sb.size();
            checks += sb.size();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
